// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//   Sprite-memory DMA engine. A write to the DMA page register halts the CPU
//   and copies 256 bytes from CPU page P ({P,00}..{P,FF}) into the PPU OAMDATA
//   register, one read cycle followed by one write cycle per byte.
//
//   Optional build macro: OAM_DMA_ALIGN_EN
//     defined   : when the HALT cycle falls on odd parity (ph=1), one idle ALIGN
//                 cycle is inserted before the first read (busy 514 cycles).
//     undefined : HALT always proceeds straight to READ (busy 513 cycles).
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [2:0] OAMDATA_SEL = 3'h4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_we,
    input  logic [7:0]  cpu_data_i,
    input  logic [7:0]  mem_data_i,
    output logic        cpu_halt,
    output logic [15:0] mem_addr_o,
    output logic        mem_rd,
    output logic        ppu_cs,
    output logic        ppu_rw,
    output logic [2:0]  ppu_sel,
    output logic [7:0]  ppu_data_o,
    output logic        busy,
    output logic        done
);

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        ph;       // free-running cycle parity
    logic [7:0]  page;     // latched source page P
    logic [7:0]  idx;      // byte index within the page
    logic [7:0]  data_q;   // last byte written to OAMDATA, held between writes
    logic [2:0]  sel_q;    // last register select, held between writes
    logic        done_q;

    logic        last_byte;
    assign last_byte = (idx == 8'hFF);

    // Parity bit toggles on every clock regardless of state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= 1'b0;
        end else begin
            ph <= ~ph;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dma_we is only looked at in IDLE, so it is ignored while busy.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (dma_we) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                state_nxt = (ph && ALIGN_ON) ? ALIGN : READ;
            end
            ALIGN: begin
                state_nxt = READ;
            end
            READ: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                state_nxt = last_byte ? IDLE : READ;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Page latch and byte index: captured on start, stepped after each OAMDATA write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page <= '0;
            idx  <= '0;
        end else begin
            if (state == IDLE && dma_we) begin
                page <= cpu_data_i;
                idx  <= '0;
            end else if (state == WRITE && !last_byte) begin
                idx <= idx + 8'd1;
            end
        end
    end

    // Hold registers for the PPU-facing data/select, plus the completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            done_q <= 1'b0;
        end else begin
            if (state == WRITE) begin
                data_q <= mem_data_i;
                sel_q  <= OAMDATA_SEL;
            end
            done_q <= (state == WRITE) && last_byte;
        end
    end

    // Output decode. During WRITE the read data is forwarded straight to the PPU
    // so it is valid while ppu_cs is high; afterwards the registered copy holds it.
    always_comb begin
        busy       = (state != IDLE);
        cpu_halt   = (state != IDLE);
        mem_rd     = (state == READ);
        mem_addr_o = (state == READ) ? {page, idx} : '0;
        ppu_cs     = (state == WRITE);
        ppu_rw     = (state != WRITE);
        ppu_sel    = (state == WRITE) ? OAMDATA_SEL : sel_q;
        ppu_data_o = (state == WRITE) ? mem_data_i : data_q;
        done       = done_q;
    end

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//   Directed bench for oam_dma. Source memory returns the low address byte one
//   cycle after each read. Honors OAM_DMA_ALIGN_EN for the expected busy length.
// ---------------------------------------------------------------------------
module tb_oam_dma;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_we;
    logic [7:0]  cpu_data_i;
    logic [7:0]  mem_data_i;
    logic        cpu_halt;
    logic [15:0] mem_addr_o;
    logic        mem_rd;
    logic        ppu_cs;
    logic        ppu_rw;
    logic [2:0]  ppu_sel;
    logic [7:0]  ppu_data_o;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic tb_ph;
    logic cur_hp;

    oam_dma #(.OAMDATA_SEL(3'h4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dma_we     (dma_we),
        .cpu_data_i (cpu_data_i),
        .mem_data_i (mem_data_i),
        .cpu_halt   (cpu_halt),
        .mem_addr_o (mem_addr_o),
        .mem_rd     (mem_rd),
        .ppu_cs     (ppu_cs),
        .ppu_rw     (ppu_rw),
        .ppu_sel    (ppu_sel),
        .ppu_data_o (ppu_data_o),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Reference parity: reset to 0, toggles every clock.
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ph <= 1'b0;
        else     tb_ph <= ~tb_ph;
    end

    // Source memory: byte value equals low address byte, one cycle latency.
    always @(posedge clk) mem_data_i <= mem_addr_o[7:0];

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy),       32'd0);
        check({tag, "_halt"},  32'(cpu_halt),   32'd0);
        check({tag, "_done"},  32'(done),       32'd0);
        check({tag, "_rd"},    32'(mem_rd),     32'd0);
        check({tag, "_addr"},  32'(mem_addr_o), 32'd0);
        check({tag, "_cs"},    32'(ppu_cs),     32'd0);
        check({tag, "_rw"},    32'(ppu_rw),     32'd1);
        check({tag, "_sel"},   32'(ppu_sel),    32'd0);
        check({tag, "_data"},  32'(ppu_data_o), 32'd0);
    endtask

    // Pulse dma_we for one clock; HALT parity is the value ph takes at that edge.
    task automatic launch(input logic [7:0] page);
        dma_we     = 1'b1;
        cpu_data_i = page;
        cur_hp     = ~tb_ph;
        tick();
        dma_we     = 1'b0;
    endtask

    // Walk a transfer from HALT to the done cycle (returns sitting in the done cycle).
    task automatic run_xfer(input string tag, input logic [7:0] page,
                            input int strike_at, input logic [7:0] page2);
        int busy_n = 0;
        int n_rd = 0;
        int n_wr = 0;
        int n_idle = 0;
        int n_done = 0;
        int exp_len;
        logic [15:0] last_addr = '0;
        check({tag, "_halt_busy"}, 32'(busy),     32'd1);
        check({tag, "_halt_cpu"},  32'(cpu_halt), 32'd1);
        for (int c = 0; c < 600 && busy === 1'b1; c++) begin
            dma_we = 1'b0;
            busy_n++;
            if (done === 1'b1) n_done++;
            if (mem_rd === 1'b1) begin
                check({tag, "_rd_addr"}, 32'(mem_addr_o), 32'({page, n_rd[7:0]}));
                last_addr = mem_addr_o;
                n_rd++;
            end else begin
                check({tag, "_addr_zero"}, 32'(mem_addr_o), 32'd0);
            end
            if (ppu_cs === 1'b1) begin
                check({tag, "_wr_data"}, 32'(ppu_data_o), 32'(n_wr[7:0]));
                check({tag, "_wr_rw"},   32'(ppu_rw),     32'd0);
                check({tag, "_wr_sel"},  32'(ppu_sel),    32'd4);
                n_wr++;
                if (n_wr == strike_at) begin
                    dma_we     = 1'b1;
                    cpu_data_i = page2;
                end
            end else begin
                check({tag, "_rw_idle"}, 32'(ppu_rw), 32'd1);
            end
            if (mem_rd !== 1'b1 && ppu_cs !== 1'b1) n_idle++;
            tick();
        end
        dma_we  = 1'b0;
        exp_len = 513 + ((ALIGN && cur_hp) ? 1 : 0);
        check({tag, "_busy_end"},  32'(busy),     32'd0);
        check({tag, "_halt_end"},  32'(cpu_halt), 32'd0);
        check({tag, "_busy_len"},  32'(busy_n),   32'(exp_len));
        check({tag, "_n_reads"},   32'(n_rd),     32'd256);
        check({tag, "_n_writes"},  32'(n_wr),     32'd256);
        check({tag, "_n_idle"},    32'(n_idle),   32'(1 + ((ALIGN && cur_hp) ? 1 : 0)));
        check({tag, "_early_done"},32'(n_done),   32'd0);
        check({tag, "_last_addr"}, 32'(last_addr),32'({page, 8'hFF}));
        check({tag, "_done"},      32'(done),     32'd1);
    endtask

    // One idle cycle after done: pulse gone, bus quiet, PPU select/data held.
    task automatic idle_after(input string tag);
        tick();
        check({tag, "_done_low"}, 32'(done),       32'd0);
        check({tag, "_busy"},     32'(busy),       32'd0);
        check({tag, "_rd"},       32'(mem_rd),     32'd0);
        check({tag, "_addr"},     32'(mem_addr_o), 32'd0);
        check({tag, "_cs"},       32'(ppu_cs),     32'd0);
        check({tag, "_rw"},       32'(ppu_rw),     32'd1);
        check({tag, "_sel_hold"}, 32'(ppu_sel),    32'd4);
        check({tag, "_data_hold"},32'(ppu_data_o), 32'hFF);
    endtask

    initial begin
        int n_wr;
        rst        = 1'b1;
        dma_we     = 1'b0;
        cpu_data_i = 8'h00;
        mem_data_i = 8'h00;
        cur_hp     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Page 02, HALT on even parity.
        if (tb_ph !== 1'b1) tick();
        launch(8'h02);
        check("p02_hp0", 32'(cur_hp), 32'd0);
        run_xfer("p02_even", 8'h02, -1, 8'h00);
        idle_after("p02_even_idle");

        // Page 02, HALT on odd parity.
        if (tb_ph !== 1'b0) tick();
        launch(8'h02);
        check("p02_hp1", 32'(cur_hp), 32'd1);
        run_xfer("p02_odd", 8'h02, -1, 8'h00);
        idle_after("p02_odd_idle");

        // Page FF: ends at FFFF, no wrap to 0000.
        launch(8'hFF);
        run_xfer("pFF", 8'hFF, -1, 8'h00);
        idle_after("pFF_idle");
        idle_after("pFF_idle2");

        // Page 03 with a page-05 strobe after byte 100; then restart in the done cycle.
        launch(8'h03);
        run_xfer("p03_strike", 8'h03, 100, 8'h05);
        launch(8'h04);
        run_xfer("p04_chain", 8'h04, -1, 8'h00);
        idle_after("p04_idle");

        // Reset during the WRITE of byte 10.
        launch(8'h09);
        n_wr = 0;
        for (int c = 0; c < 100; c++) begin
            if (ppu_cs === 1'b1) begin
                if (n_wr == 10) break;
                n_wr++;
            end
            tick();
        end
        check("rst_mid_in_write", 32'(ppu_cs), 32'd1);
        check("rst_mid_byte10",   32'(ppu_data_o), 32'd10);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            check("post_rst_cs",   32'(ppu_cs), 32'd0);
            check("post_rst_rd",   32'(mem_rd), 32'd0);
            check("post_rst_busy", 32'(busy),   32'd0);
        end
        launch(8'h07);
        run_xfer("p07_after_rst", 8'h07, -1, 8'h00);
        idle_after("p07_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
